// File: rtl/pool_output_collector.sv
// pool_output_collector
//   Collects pooled samples from a max-pooling engine. Each sample is tagged
//   with its pooled (x, y) position and queued in a first-word-fall-through
//   FIFO for a downstream consumer. The block also tracks the per-frame maximum
//   and flags samples that are dropped while the FIFO is full.
//
// Parameters
//   WIDTH, HEIGHT : pre-pool frame size in pixels (even). The pooled grid is
//                   WIDTH/2 x HEIGHT/2.
//   DEPTH         : FIFO entries (power of two).
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous, active-low reset
//   pool_in      pooled sample                    pool_valid  sample strobe (no backpressure)
//   out_data     head sample                      out_x/out_y head coordinates
//   out_valid    FIFO non-empty                   out_ready   downstream accepts head
//   frame_done   one-cycle pulse after the last sample of a frame
//   frame_max    maximum sample of the last completed frame
//   overflow     sticky: a sample was dropped on a full FIFO
//   fifo_count   current FIFO occupancy
module pool_output_collector #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    pool_in,
  input  logic          pool_valid,
  output logic [7:0]    out_data,
  output logic [9:0]    out_x,
  output logic [8:0]    out_y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          frame_done,
  output logic [7:0]    frame_max,
  output logic          overflow,
  output logic [CW-1:0] fifo_count
);

  localparam int PW = WIDTH / 2;
  localparam int PH = HEIGHT / 2;

  typedef struct packed {
    logic [8:0] y;
    logic [9:0] x;
    logic [7:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [9:0]    px;
  logic [8:0]    py;
  logic [7:0]    run_max;

  logic       full;
  logic       pop;
  logic       push;
  logic       last_x;
  logic       last_y;
  logic       first_sample;
  logic [7:0] next_max;

  assign out_valid    = (fifo_count != '0);
  assign full         = (fifo_count == CW'(DEPTH));
  // A pop needs a non-empty FIFO, so out_ready on an empty FIFO is ignored
  // even when a write lands on the same edge.
  assign pop          = out_valid & out_ready;
  // A full FIFO still takes a write if the head leaves on the same edge.
  assign push         = pool_valid & (~full | pop);

  assign last_x       = (px == 10'(PW - 1));
  assign last_y       = (py == 9'(PH - 1));
  assign first_sample = (px == '0) && (py == '0);

  // The running maximum restarts on the first sample of every frame, so it
  // never needs an explicit clear between frames.
  assign next_max = first_sample           ? pool_in :
                    (pool_in > run_max)    ? pool_in : run_max;

  entry_t head;
  assign head     = mem[rd_ptr];
  assign out_data = head.data;
  assign out_x    = head.x;
  assign out_y    = head.y;

  // NOTE: the storage array is deliberately left out of reset; fifo_count
  // gates out_valid, so stale contents are never presented as valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{y: py, x: px, data: pool_in};
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of its peers (px/py/run_max read each other here).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      px         <= '0;
      py         <= '0;
      run_max    <= '0;
      frame_done <= 1'b0;
      frame_max  <= '0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      if (pool_valid) begin
        if (!push) overflow <= 1'b1;

        // Geometry advances on every sample, dropped or not.
        run_max <= next_max;
        if (last_x) begin
          px <= '0;
          py <= last_y ? '0 : py + 1'b1;
        end else begin
          px <= px + 1'b1;
        end

        if (last_x && last_y) begin
          frame_max  <= next_max;
          frame_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_output_collector.sv
// tb_pool_output_collector
//   Drives pool_output_collector (4x4 frame, 4-entry FIFO) with directed
//   scenarios and randomized traffic, comparing every cycle against a
//   queue-based reference model.
module tb_pool_output_collector;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 4;
  localparam int DEPTH  = 4;
  localparam int PW     = WIDTH / 2;
  localparam int PH     = HEIGHT / 2;
  localparam int NPIX   = PW * PH;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pool_in;
  logic       pool_valid;
  logic [7:0] out_data;
  logic [9:0] out_x;
  logic [8:0] out_y;
  logic       out_valid;
  logic       out_ready;
  logic       frame_done;
  logic [7:0] frame_max;
  logic       overflow;
  logic [2:0] fifo_count;

  pool_output_collector #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .pool_in    (pool_in),
    .pool_valid (pool_valid),
    .out_data   (out_data),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .frame_max  (frame_max),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of {y, x, data} entries plus the list of sample
  // values seen in the current frame.
  logic [26:0] q[$];
  int          vals[$];
  int unsigned s_idx;
  bit          m_ovf;
  bit          m_done;
  int          m_fmax;

  function automatic void model_reset();
    q.delete();
    vals.delete();
    s_idx  = 0;
    m_ovf  = 1'b0;
    m_done = 1'b0;
    m_fmax = 0;
  endfunction

  function automatic void model_step(input bit v, input logic [7:0] d, input bit r);
    bit pop  = (q.size() > 0) && r;
    bit room = (q.size() < DEPTH);
    int idx, x, y, m;
    m_done = 1'b0;
    if (pop) void'(q.pop_front());
    if (v) begin
      idx = int'(s_idx % NPIX);
      x   = idx % PW;
      y   = idx / PW;
      if (idx == 0) vals.delete();
      vals.push_back(int'(d));
      if (room || pop) q.push_back({9'(y), 10'(x), d});
      else             m_ovf = 1'b1;
      if (idx == NPIX - 1) begin
        m = 0;
        foreach (vals[i]) if (vals[i] > m) m = vals[i];
        m_fmax = m;
        m_done = 1'b1;
      end
      s_idx++;
    end
  endfunction

  task automatic compare(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 32'(q.size() != 0));
    check({tag, ".count"}, 32'(fifo_count), 32'(q.size()));
    check({tag, ".ovf"},   32'(overflow), 32'(m_ovf));
    check({tag, ".done"},  32'(frame_done), 32'(m_done));
    check({tag, ".fmax"},  32'(frame_max), 32'(m_fmax));
    if (q.size() != 0) check({tag, ".head"}, 32'({out_y, out_x, out_data}), 32'(q[0]));
  endtask

  // Called about 1 ns after a rising edge; returns 1 ns after the next one.
  task automatic cycle(input string tag, input bit v, input logic [7:0] d, input bit r);
    pool_valid = v;
    pool_in    = d;
    out_ready  = r;
    @(posedge clk);
    model_step(v, d, r);
    #1;
    compare(tag);
  endtask

  // Asserts reset between edges, checks the asynchronous clear, then releases
  // before the next edge.
  task automatic do_reset(input string tag);
    pool_valid = 1'b0;
    out_ready  = 1'b0;
    reset      = 1'b0;
    #1;
    model_reset();
    compare(tag);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f34[4] = '{8'd60, 8'd80, 8'd75, 8'd85};
    logic [7:0] f37[8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd9, 8'd5, 8'd5, 8'd5};
    logic [7:0] f35[5] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
    logic [7:0] cnt_max;
    bit         rbias;

    pool_in    = '0;
    pool_valid = 1'b0;
    out_ready  = 1'b0;
    do_reset("rst0");
    @(posedge clk); #1;
    compare("idle");

    // Single frame, downstream always ready.
    for (int i = 0; i < 4; i++) cycle("f34", 1'b1, f34[i], 1'b1);
    check("f34.done", 32'(frame_done), 32'd1);
    check("f34.max", 32'(frame_max), 32'd85);
    cycle("f34.tail", 1'b0, 8'd0, 1'b1);
    check("f34.done_cleared", 32'(frame_done), 32'd0);

    // Two back-to-back frames.
    for (int i = 0; i < 8; i++) begin
      cycle("f37", 1'b1, f37[i], 1'b1);
      if (i == 3) check("f37.max1", 32'(frame_max), 32'd4);
    end
    check("f37.max2", 32'(frame_max), 32'd9);
    cycle("f37.tail", 1'b0, 8'd0, 1'b1);

    // Overflow: five samples into a stalled 4-entry FIFO, then drain.
    do_reset("rst1");
    for (int i = 0; i < 5; i++) cycle("f35", 1'b1, f35[i], 1'b0);
    check("f35.count", 32'(fifo_count), 32'd4);
    check("f35.ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 5; i++) cycle("f35.drain", 1'b0, 8'd0, 1'b1);

    // Full FIFO with write and pop on the same edge.
    do_reset("rst2");
    for (int i = 0; i < 4; i++) cycle("f36.fill", 1'b1, 8'(100 + i), 1'b0);
    cycle("f36.both", 1'b1, 8'd77, 1'b1);
    check("f36.count", 32'(fifo_count), 32'd4);
    check("f36.ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) cycle("f36.drain", 1'b0, 8'd0, 1'b1);

    // Empty FIFO: write with out_ready high must still land.
    cycle("f25.write", 1'b1, 8'd33, 1'b1);
    check("f25.count", 32'(fifo_count), 32'd1);
    cycle("f25.pop", 1'b0, 8'd0, 1'b1);

    // Reset mid-frame discards contents and geometry.
    do_reset("rst3");
    for (int i = 0; i < 3; i++) cycle("f38.pre", 1'b1, 8'(200 + i), 1'b0);
    do_reset("rst4");
    check("f38.count", 32'(fifo_count), 32'd0);
    check("f38.valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) cycle("f38.post", 1'b1, 8'(i + 1), 1'b0);
    check("f38.head_xy", 32'({out_y, out_x}), 32'd0);
    for (int i = 0; i < 4; i++) cycle("f38.drain", 1'b0, 8'd0, 1'b1);

    // Sparse input with toggling out_ready.
    cnt_max = 0;
    for (int i = 0; i < 36; i++) begin
      cycle("f39", (i % 3) == 0, 8'($urandom), (i % 2) == 1);
      if (8'(fifo_count) > cnt_max) cnt_max = 8'(fifo_count);
    end
    check("f39.cnt_le2", 32'(cnt_max <= 2), 32'd1);
    check("f39.no_ovf", 32'(overflow), 32'd0);

    // Randomized traffic with varying downstream pressure and one mid-run reset.
    rbias = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rbias = ~rbias;
      if (i == 1500) do_reset("rst_rand");
      cycle("rand", $urandom_range(0, 3) != 0, 8'($urandom),
            rbias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pool_output_collector.md
POOL_OUTPUT_COLLECTOR -- requirements
Module: pool_output_collector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 640: input (pre-pool) frame width in pixels, even, 4..2048.
REQ-002 The block SHALL have parameter HEIGHT, default 480: input frame height in pixels, even, 4..1024.
REQ-003 The block SHALL have parameter DEPTH, default 16: FIFO entries, power of two, 2..256.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 pool_in  input  8  pooled sample from the max-pooling engine.
REQ-007 pool_valid  input  1  pool_in is valid this cycle; no backpressure toward the source.
REQ-008 out_data  output  8  head-of-FIFO pooled sample.
REQ-009 out_x  output  10  pooled column of out_data, 0..WIDTH/2-1.
REQ-010 out_y  output  9  pooled row of out_data, 0..HEIGHT/2-1.
REQ-011 out_valid  output  1  FIFO non-empty; out_data/out_x/out_y valid.
REQ-012 out_ready  input  1  downstream accepts the head entry when high with out_valid.
REQ-013 frame_done  output  1  one-cycle pulse after the last pooled sample of a frame is accepted.
REQ-014 frame_max  output  8  maximum pool_in of the most recently completed frame.
REQ-015 overflow  output  1  sticky: a sample was dropped because the FIFO was full.
REQ-016 fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 Each cycle with pool_valid=1 SHALL constitute one input sample, tagged with counters (px, py).
REQ-018 px SHALL increment per input sample and wrap from WIDTH/2-1 to 0; on that wrap py SHALL increment, wrapping from HEIGHT/2-1 to 0.
REQ-019 Counters SHALL advance on every input sample, including dropped ones, so geometry never slips.
REQ-020 A non-dropped sample SHALL be written into the FIFO as {py, px, pool_in}.
REQ-021 FIFO SHALL be first-word-fall-through: an entry written at edge N into an empty FIFO SHALL show out_valid=1 and its fields from edge N onward (one-cycle latency).
REQ-022 Pop SHALL occur at an edge where out_valid=1 and out_ready=1; out_ready while empty SHALL be ignored.
REQ-023 Full FIFO with pool_valid=1 and no pop at the same edge: sample SHALL be dropped and overflow SHALL be set, held until reset.
REQ-024 Full FIFO with simultaneous pop: write SHALL be accepted, fifo_count unchanged, no overflow.
REQ-025 Empty FIFO with simultaneous write and out_ready: out_ready SHALL be ignored that edge; entry lands, count becomes 1.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH; fifo_count SHALL equal writes minus pops, 0..DEPTH.
REQ-027 A running maximum SHALL track pool_in of every input sample in the frame (dropped included); it SHALL restart with the first sample of each frame.
REQ-028 At the input sample with px=WIDTH/2-1, py=HEIGHT/2-1: frame_max SHALL load max(running max, that pool_in) at that edge, and frame_done SHALL be 1 for exactly the following cycle.
REQ-029 frame_done SHALL be unaffected by FIFO full/drop state.
REQ-030 Outputs out_data, out_x, out_y SHALL be don't-care when out_valid=0.

Reset
REQ-031 reset=0 SHALL immediately clear px, py, running max, pointers, fifo_count=0, out_valid=0, frame_done=0, frame_max=0, overflow=0, independent of clk.
REQ-032 Reset asserted mid-frame SHALL discard FIFO contents and partial-frame state; the first sample after release SHALL be tagged (0,0).
REQ-033 No sample SHALL be accepted on the edge on which reset is released... pool_valid is only sampled while reset=1 at the edge.

Verification
REQ-034 WIDTH=4,HEIGHT=4, out_ready=1: pool_in 60,80,75,85 on consecutive cycles -> out (0,0,60),(1,0,80),(0,1,75),(1,1,85) in order, frame_done one cycle after 85, frame_max=85.
REQ-035 DEPTH=4, out_ready=0, 5 samples 10..50 -> fifo_count=4, overflow=1, sample 50 absent; then out_ready=1 drains 10,20,30,40 with coordinates (0,0),(1,0),(0,1),(1,1).
REQ-036 DEPTH=4 full, pool_valid=1 and out_ready=1 same edge -> count stays 4, overflow stays 0, new sample appears last.
REQ-037 Two back-to-back frames (4x4): frame 1 values 1,2,3,4, frame 2 values 9,5,5,5 -> frame_max=4 then 9, two frame_done pulses, second frame tagged from (0,0).
REQ-038 Reset low after 3 samples of a frame, then release -> count=0, out_valid=0, next sample tagged (0,0), no frame_done until 4 further samples.
REQ-039 Sparse input: pool_valid high every 3rd cycle, out_ready toggling -> all entries delivered in order, no loss, fifo_count never exceeds 2.
